// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit with HI/LO registers.
// One shift-add or restoring-divide step per cycle, WIDTH cycles per op.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [2:0]       i_alu_op,
    input  logic [5:0]       i_func,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_result
);
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic w_rtype, w_mult, w_divu, w_mfhi, w_mflo, w_mthi, w_mtlo;
    logic w_issued, w_open;

    assign w_rtype  = i_en && (i_alu_op == 3'b010);
    assign w_mult   = w_rtype && (i_func == F_MULTU);
    assign w_divu   = w_rtype && (i_func == F_DIVU);
    assign w_mfhi   = w_rtype && (i_func == F_MFHI);
    assign w_mflo   = w_rtype && (i_func == F_MFLO);
    assign w_mthi   = w_rtype && (i_func == F_MTHI);
    assign w_mtlo   = w_rtype && (i_func == F_MTLO);
    assign w_issued = w_mult | w_divu | w_mfhi | w_mflo | w_mthi | w_mtlo;
    assign w_open   = (r_state != S_RUN);

    assign o_stall = !i_rst && w_issued && !w_open;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;

    always_comb begin
        o_result = '0;
        if (!i_rst && w_open) begin
            if (w_mfhi)
                o_result = r_hi;
            else if (w_mflo)
                o_result = r_lo;
        end
    end

    // r_acc: running high half (mul) or partial remainder (div);
    // r_q: multiplier shifting out (mul) or dividend/quotient (div).
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_acc_nx;
    logic [WIDTH-1:0] w_q_nx;

    assign w_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_d} : {(WIDTH+1){1'b0}});
    assign w_shl  = {r_acc, r_q[WIDTH-1]};
    assign w_ge   = (w_shl >= {1'b0, r_d});
    assign w_diff = w_shl[WIDTH-1:0] - r_d;

    always_comb begin
        w_acc_nx = w_sum[WIDTH:1];
        w_q_nx   = {w_sum[0], r_q[WIDTH-1:1]};
        if (r_div) begin
            w_acc_nx = w_ge ? w_diff : w_shl[WIDTH-1:0];
            w_q_nx   = {r_q[WIDTH-2:0], w_ge};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_acc   <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (w_mult || w_divu) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_div   <= w_divu;
                        r_acc   <= '0;
                        r_q     <= w_divu ? i_a : i_b;
                        r_d     <= w_divu ? i_b : i_a;
                    end else if (w_mthi) begin
                        r_hi <= i_a;
                    end else if (w_mtlo) begin
                        r_lo <= i_a;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nx;
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_hi    <= w_acc_nx;
                        r_lo    <= w_q_nx;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: arithmetic reference model,
// queued expectations, monitors check on o_done and MFHI/MFLO reads.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_ADDU  = 6'b100001;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [2:0]   aop;
    logic [5:0]   func;
    logic [W-1:0] a, b;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo, res;

    logic         en8;
    logic [2:0]   aop8;
    logic [5:0]   func8;
    logic [7:0]   a8, b8;
    logic         busy8, stall8, done8;
    logic [7:0]   hi8, lo8, res8;

    int total = 0;
    int bad = 0;
    int busy_run = 0;
    int busy_run8 = 0;
    int n, nst, k;
    logic seen;

    logic [2*W-1:0] q_done[$];
    logic [W-1:0]   q_res[$];
    logic [15:0]    q_done8[$];
    logic [2*W-1:0] e_d;
    logic [W-1:0]   e_r;
    logic [15:0]    e_d8;
    logic [W-1:0]   m_hi, m_lo;

    muldiv_unit #(.WIDTH(W)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_alu_op(aop),
        .i_func(func), .i_a(a), .i_b(b),
        .o_busy(busy), .o_stall(stall), .o_done(done),
        .o_hi(hi), .o_lo(lo), .o_result(res)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_en(en8), .i_alu_op(aop8),
        .i_func(func8), .i_a(a8), .i_b(b8),
        .o_busy(busy8), .o_stall(stall8), .o_done(done8),
        .o_hi(hi8), .o_lo(lo8), .o_result(res8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        en = 1'b0; aop = 3'b000; func = 6'd0; a = '0; b = '0;
    endtask

    task automatic wait_done();
        int c = 0;
        while (!done && c < W + 4) begin
            tick();
            c++;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    // Returns in the DONE cycle so the caller may issue back-to-back.
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] x,
                          input logic [W-1:0] y);
        logic [2*W-1:0] p;
        if (f == F_MULTU)
            p = 64'(x) * 64'(y);
        else if (y == '0)
            p = {x, {W{1'b1}}};
        else
            p = {x % y, x / y};
        m_hi = p[2*W-1:W];
        m_lo = p[W-1:0];
        q_done.push_back(p);
        en = 1'b1; aop = 3'b010; func = f; a = x; b = y;
        tick();
        idle_in();
        wait_done();
    endtask

    task automatic mt(input logic [5:0] f, input logic [W-1:0] v);
        if (f == F_MTHI) m_hi = v;
        else m_lo = v;
        en = 1'b1; aop = 3'b010; func = f; a = v; b = $urandom;
        tick();
        idle_in();
    endtask

    task automatic mf(input logic [5:0] f);
        q_res.push_back((f == F_MFHI) ? m_hi : m_lo);
        en = 1'b1; aop = 3'b010; func = f; a = $urandom; b = $urandom;
        tick();
        idle_in();
    endtask

    task automatic noise();
        int v = $urandom_range(0, 2);
        en = (v != 0); aop = (v == 1) ? 3'b000 : 3'b010;
        func = (v == 2) ? F_ADDU : ((v == 1) ? F_MULTU : F_MTHI);
        a = $urandom; b = $urandom;
        #1;
        chk("noise_stall", 64'(stall), 64'd0);
        tick();
        idle_in();
        chk("noise_busy", 64'(busy), 64'd0);
        chk("noise_hi", 64'(hi), 64'(m_hi));
    endtask

    task automatic run_op8(input logic [5:0] f, input logic [7:0] x,
                           input logic [7:0] y);
        logic [15:0] p;
        int c = 0;
        if (f == F_MULTU)
            p = 16'(x) * 16'(y);
        else if (y == 8'd0)
            p = {x, 8'hFF};
        else
            p = {x % y, x / y};
        q_done8.push_back(p);
        en8 = 1'b1; aop8 = 3'b010; func8 = f; a8 = x; b8 = y;
        tick();
        en8 = 1'b0; aop8 = 3'b000; func8 = 6'd0;
        chk("busy8_after_issue", 64'(busy8), 64'd1);
        while (!done8 && c < 12) begin
            tick();
            c++;
        end
        if (!done8) chk("done8_timeout", 64'd0, 64'd1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (q_done.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    e_d = q_done.pop_front();
                    chk("done_hi", 64'(hi), 64'(e_d[2*W-1:W]));
                    chk("done_lo", 64'(lo), 64'(e_d[W-1:0]));
                    chk("busy_cycles", 64'(busy_run), 64'(W));
                end
                busy_run = 0;
            end
            if (en && aop == 3'b010 && (func == F_MFHI || func == F_MFLO)) begin
                if (stall) begin
                    chk("stalled_result", 64'(res), 64'd0);
                end else if (q_res.size() == 0) begin
                    chk("mf_unexpected", 64'd1, 64'd0);
                end else begin
                    e_r = q_res.pop_front();
                    chk("mf_result", 64'(res), 64'(e_r));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            busy_run8 = 0;
        end else begin
            if (busy8) busy_run8++;
            if (done8) begin
                if (q_done8.size() == 0) begin
                    chk("done8_unexpected", 64'd1, 64'd0);
                end else begin
                    e_d8 = q_done8.pop_front();
                    chk("done8_hi", 64'(hi8), 64'(e_d8[15:8]));
                    chk("done8_lo", 64'(lo8), 64'(e_d8[7:0]));
                    chk("busy8_cycles", 64'(busy_run8), 64'd8);
                end
                busy_run8 = 0;
            end
        end
    end

    initial begin
        rst = 1'b1;
        en8 = 1'b0; aop8 = 3'b000; func8 = 6'd0; a8 = 8'd0; b8 = 8'd0;
        en = 1'b1; aop = 3'b010; func = F_MFHI; a = '0; b = '0;
        tick();
        tick();
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_result", 64'(res), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        idle_in();
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        tick();

        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("mul_max_hi", 64'(hi), 64'hFFFFFFFE);
        chk("mul_max_lo", 64'(lo), 64'h00000001);
        tick();
        run_op(F_DIVU, 32'd100, 32'd7);
        chk("div_100_7_lo", 64'(lo), 64'd14);
        chk("div_100_7_hi", 64'(hi), 64'd2);
        tick();
        run_op(F_DIVU, 32'd5, 32'd0);
        chk("div_by0_lo", 64'(lo), 64'hFFFFFFFF);
        chk("div_by0_hi", 64'(hi), 64'd5);
        tick();

        mt(F_MTHI, 32'h1234);
        mf(F_MFHI);
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mthi_lo_kept", 64'(lo), 64'hFFFFFFFF);

        m_hi = '0;
        m_lo = 32'd12;
        q_done.push_back(64'd12);
        en = 1'b1; aop = 3'b010; func = F_MULTU; a = 32'd3; b = 32'd4;
        tick();
        func = F_MFLO; a = '0; b = '0;
        q_res.push_back(32'd12);
        n = 0;
        nst = 0;
        while (!done && n < W + 4) begin
            if (stall) nst++;
            if (n == 5) begin
                func = F_ADDU;
                #1;
                chk("addu_no_stall", 64'(stall), 64'd0);
                func = F_MFLO;
            end
            tick();
            n++;
        end
        chk("mflo_stall_cycles", 64'(nst), 64'(W));
        chk("mflo_done_stall", 64'(stall), 64'd0);
        chk("mflo_done_result", 64'(res), 64'd12);
        tick();
        idle_in();

        en = 1'b1; aop = 3'b010; func = F_MULTU; a = $urandom; b = $urandom;
        tick();
        idle_in();
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        m_hi = '0;
        m_lo = '0;
        seen = 1'b0;
        repeat (W + 2) begin
            if (done) seen = 1'b1;
            tick();
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        mf(F_MFHI);

        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 6);
            case (k)
                0: run_op(F_MULTU, $urandom, $urandom);
                1: run_op(F_DIVU, $urandom,
                          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1))
                                                      : ($urandom >> $urandom_range(0, 31)));
                2: mt(F_MTHI, $urandom);
                3: mt(F_MTLO, $urandom);
                4: mf(F_MFHI);
                5: mf(F_MFLO);
                default: noise();
            endcase
            if ($urandom_range(0, 1) == 1) tick();
        end
        repeat (2) tick();

        run_op8(F_MULTU, 8'hFF, 8'hFF);
        chk("mul8_hi", 64'(hi8), 64'hFE);
        chk("mul8_lo", 64'(lo8), 64'h01);
        run_op8(F_DIVU, 8'd200, 8'd9);
        chk("div8_lo", 64'(lo8), 64'd22);
        chk("div8_hi", 64'(hi8), 64'd2);
        for (int i = 0; i < 6; i++) begin
            run_op8(($urandom_range(0, 1) == 1) ? F_MULTU : F_DIVU,
                    8'($urandom), 8'($urandom_range(0, 255) >> $urandom_range(0, 7)));
        end

        repeat (4) tick();
        chk("q_done_empty", 64'(q_done.size()), 64'd0);
        chk("q_res_empty", 64'(q_res.size()), 64'd0);
        chk("q_done8_empty", 64'(q_done8.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
